wb_arbiter: RTL

Write-back arbiter and buffer that drives the register file's single write port (rd address, rd data, write enable). It accepts results from the ALU and the load/store unit, possibly both in the same cycle, queues them in program-arrival order, and retires exactly one write per cycle. It also exports a per-register pending mask for hazard detection and, optionally, a forwarding lookup into queued results.

---
 rtl/wb_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: queues ALU/LSU results in arrival order and retires one register write per cycle.
// Define WB_FWD_EN to enable the forwarding lookup (o_fwd_hit/o_fwd_data) into queued results.
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_lsu_valid,
    input  logic [ADDR_W-1:0]          i_lsu_rd,
    input  logic [DATA_W-1:0]          i_lsu_data,
    output logic                       o_lsu_ready,
    input  logic                       i_alu_valid,
    input  logic [ADDR_W-1:0]          i_alu_rd,
    input  logic [DATA_W-1:0]          i_alu_data,
    output logic                       o_alu_ready,
    output logic                       o_rd_wren,
    output logic [ADDR_W-1:0]          o_rd_addr,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic [31:0]                o_pending,
    output logic [$clog2(DEPTH):0]     o_count,
    input  logic [ADDR_W-1:0]          i_fwd_addr,
    output logic                       o_fwd_hit,
    output logic [DATA_W-1:0]          o_fwd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH - 1);

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_wren_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              lsu_push;
    logic              alu_push;
    logic              pop;
    logic [PTR_W-1:0]  alu_slot;
    logic [DEPTH-1:0]  entry_valid;
    logic [31:0]       pending;

    // Readies look only at the registered count so they never combinationally depend on valid.
    assign o_lsu_ready = (count_q < DEPTH_C);
    assign o_alu_ready = (count_q < DEPTH_M1_C);

    assign lsu_push = i_lsu_valid && o_lsu_ready && (i_lsu_rd != '0);
    assign alu_push = i_alu_valid && o_alu_ready && (i_alu_rd != '0);
    assign pop      = (count_q != '0);

    // The ALU entry lands behind the LSU entry when both push together.
    assign alu_slot = wr_ptr_q + PTR_W'(lsu_push);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(lsu_push) + PTR_W'(alu_push);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign count_d  = count_q + CNT_W'(lsu_push) + CNT_W'(alu_push) - CNT_W'(pop);

    always_ff @(posedge i_clk) begin
        if (lsu_push) begin
            mem_addr_q[wr_ptr_q] <= i_lsu_rd;
            mem_data_q[wr_ptr_q] <= i_lsu_data;
        end
        if (alu_push) begin
            mem_addr_q[alu_slot] <= i_alu_rd;
            mem_data_q[alu_slot] <= i_alu_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_wren_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_wren_q <= pop;
            if (pop) begin
                rd_addr_q <= mem_addr_q[rd_ptr_q];
                rd_data_q <= mem_data_q[rd_ptr_q];
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PTR_W-1:0] age;
        assign age             = PTR_W'(gi) - rd_ptr_q;
        assign entry_valid[gi] = ({1'b0, age} < count_q);
    end

    always_comb begin
        pending = '0;
        if (rd_wren_q) begin
            pending[rd_addr_q] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending[mem_addr_q[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

`ifdef WB_FWD_EN
    logic [PTR_W-1:0]  fwd_idx;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (i_fwd_addr != '0) begin
            if (rd_wren_q && (rd_addr_q == i_fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = rd_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                fwd_idx = rd_ptr_q + PTR_W'(k);
                if ((CNT_W'(k) < count_q) && (mem_addr_q[fwd_idx] == i_fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = mem_data_q[fwd_idx];
                end
            end
        end
    end

    assign o_fwd_hit  = fwd_hit;
    assign o_fwd_data = fwd_data;
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^i_fwd_addr;
    assign o_fwd_hit       = 1'b0;
    assign o_fwd_data      = '0;
`endif

    assign o_rd_wren = rd_wren_q;
    assign o_rd_addr = rd_addr_q;
    assign o_rd_data = rd_data_q;
    assign o_pending = pending;
    assign o_count   = count_q;

endmodule
